// File: rtl/alu_sequencer_pkg.sv
// Shared constants, opcodes and FSM state type for the ALU command sequencer.
package alu_sequencer_pkg;

  localparam int unsigned ALU_W    = 6;
  localparam int unsigned ALU_NREG = 4;
  localparam int unsigned ALU_RW   = $clog2(ALU_NREG);

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_IO  = 4'd1;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_SUB = 4'd11;
  localparam logic [3:0] OP_OR  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_IO   = 2'd2,
    S_ERR  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two asynchronous read ports, one synchronous write port, async active-low clear.
module alu_regfile #(
  parameter int unsigned W    = 6,
  parameter int unsigned NREG = 4,
  parameter int unsigned RW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic [RW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_b_o
);

  logic [W-1:0] mem_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Command-side driver for the ring ALU: fetches operands, drives the ALU, and writes back
// either the ALU result or the data returned by an external I/O transfer.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned W    = ALU_W,
  parameter int unsigned NREG = ALU_NREG,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_ra,
  input  logic [RW-1:0] instr_rb,
  output logic [W-1:0]  alu_x,
  output logic [W-1:0]  alu_y,
  output logic [3:0]    alu_op,
  input  logic [W-1:0]  alu_z,
  input  logic          alu_baf,
  input  logic          alu_iof,
  input  logic          alu_zf,
  output logic          io_req,
  output logic [W-1:0]  io_wdata,
  input  logic          io_ack,
  input  logic [W-1:0]  io_rdata,
  output logic          res_valid,
  output logic [W-1:0]  result,
  output logic          zf,
  output logic          err,
  input  logic          err_clr
);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d, io_wdata_q, io_wdata_d, result_q, result_d;
  logic [3:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          io_req_q, io_req_d, res_valid_q, res_valid_d;
  logic          zf_q, zf_d, err_q, err_d;
  logic          rf_we;
  logic [W-1:0]  rf_wdata, ra_data, rb_data;

  alu_regfile #(
    .W    (W),
    .NREG (NREG),
    .RW   (RW)
  ) u_rf (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (rf_we),
    .waddr_i   (rd_q),
    .wdata_i   (rf_wdata),
    .raddr_a_i (instr_ra),
    .rdata_a_o (ra_data),
    .raddr_b_i (instr_rb),
    .rdata_b_o (rb_data)
  );

  // Gated by rst so the source sees no ready while reset is held.
  assign instr_ready = (state_q == S_IDLE) & rst;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    rd_d        = rd_q;
    io_req_d    = io_req_q;
    io_wdata_d  = io_wdata_q;
    result_d    = result_q;
    zf_d        = zf_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = alu_z;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          x_d     = ra_data;
          y_d     = rb_data;
          op_d    = instr_op;
          rd_d    = instr_rd;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_baf) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (alu_iof) begin
          io_req_d   = 1'b1;
          io_wdata_d = x_q;
          state_d    = S_IO;
        end else begin
          rf_we       = 1'b1;
          result_d    = alu_z;
          zf_d        = alu_zf;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IO: begin
        // I/O data is stored raw; out-of-ring values are caught as BAF on later use.
        rf_wdata = io_rdata;
        if (io_ack) begin
          rf_we       = 1'b1;
          result_d    = io_rdata;
          zf_d        = (io_rdata == '0);
          res_valid_d = 1'b1;
          io_req_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      io_req_q    <= 1'b0;
      io_wdata_q  <= '0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      io_req_q    <= io_req_d;
      io_wdata_q  <= io_wdata_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_op    = op_q;
  assign io_req    = io_req_q;
  assign io_wdata  = io_wdata_q;
  assign result    = result_q;
  assign zf        = zf_q;
  assign err       = err_q;
  assign res_valid = res_valid_q;

endmodule
